// File: rtl/mvm_uart_ctrl.sv
// Frame controller between the UART and the MVM core. It packs received bytes into one
// K/X operand frame and serializes truncated result rows back out as bytes.
module mvm_uart_ctrl #(
   parameter int R             = 2,
   parameter int C             = 2,
   parameter int W_X           = 4,
   parameter int W_K           = 4,
   parameter int W_Y_OUT       = 8,
   parameter int BITS_PER_WORD = 8,
   parameter int RX_TIMEOUT    = 1024
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  rx_valid,
   input  logic [BITS_PER_WORD-1:0]              rx_data,
   output logic                                  kx_valid,
   input  logic                                  kx_ready,
   output logic [R*C*W_K+C*W_X-1:0]              kx_data,
   input  logic                                  y_valid,
   output logic                                  y_ready,
   input  logic [R*(W_X+W_K+$clog2(C))-1:0]      y_data,
   output logic                                  tx_valid,
   input  logic                                  tx_ready,
   output logic [BITS_PER_WORD-1:0]              tx_data,
   output logic                                  rx_overrun,
   output logic                                  rx_timeout,
   output logic                                  busy
);
   // Valid/ready: a transfer happens on every rising clk edge where valid and ready are
   // both high; the producer holds valid and data stable until that edge.
   localparam int W_Y        = W_X + W_K + $clog2(C);
   localparam int W_BUS_KX   = R*C*W_K + C*W_X;
   localparam int W_BUS_Y    = R*W_Y_OUT;
   localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
   localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;
   localparam int WCNT_W     = (N_WORDS_KX > 1) ? $clog2(N_WORDS_KX) : 1;
   localparam int OCNT_W     = (N_WORDS_Y > 1) ? $clog2(N_WORDS_Y) : 1;
   localparam int IDLE_W     = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

   typedef enum logic {S_IDLE, S_SEND} state_t;

   logic [WCNT_W-1:0]        wcnt;
   logic [IDLE_W-1:0]        idle_cnt;
   logic [W_BUS_KX-1:0]      asm_buf;
   logic [W_BUS_KX-1:0]      full_frame;
   logic                     last_byte;
   logic                     load;
   logic                     timeout_hit;
   state_t                   state_q, state_d;
   logic [OCNT_W-1:0]        ocnt;
   logic [W_BUS_Y-1:0]       out_reg;
   logic [W_BUS_Y-1:0]       y_trunc;
   logic [BITS_PER_WORD-1:0] out_words [N_WORDS_Y];
   logic                     last_out;

   // The final byte bypasses asm_buf so the frame can be published in the same cycle.
   always_comb begin
      full_frame = asm_buf;
      full_frame[(N_WORDS_KX-1)*BITS_PER_WORD +: BITS_PER_WORD] = rx_data;
   end

   assign last_byte   = rx_valid && (wcnt == WCNT_W'(N_WORDS_KX-1));
   assign load        = last_byte && (!kx_valid || kx_ready);
   assign timeout_hit = (RX_TIMEOUT != 0) && !rx_valid && (wcnt != '0) &&
                        (idle_cnt == IDLE_W'(RX_TIMEOUT-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt     <= '0;
         idle_cnt <= '0;
         asm_buf  <= '0;
      end else if (rx_valid) begin
         idle_cnt <= '0;
         for (int i = 0; i < N_WORDS_KX; i++) begin
            if (wcnt == WCNT_W'(i)) asm_buf[i*BITS_PER_WORD +: BITS_PER_WORD] <= rx_data;
         end
         wcnt <= last_byte ? '0 : wcnt + 1'b1;
      end else if (timeout_hit) begin
         wcnt     <= '0;
         idle_cnt <= '0;
      end else if (wcnt != '0) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // A new frame wins over the handshake that frees the pending buffer in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         kx_valid   <= 1'b0;
         kx_data    <= '0;
         rx_overrun <= 1'b0;
         rx_timeout <= 1'b0;
      end else begin
         if (load) begin
            kx_data  <= full_frame;
            kx_valid <= 1'b1;
         end else if (kx_valid && kx_ready) begin
            kx_valid <= 1'b0;
         end
         if (last_byte && !load) rx_overrun <= 1'b1;
         if (timeout_hit)        rx_timeout <= 1'b1;
      end
   end

   always_comb begin
      for (int r = 0; r < R; r++) begin
         y_trunc[r*W_Y_OUT +: W_Y_OUT] = y_data[r*W_Y +: W_Y_OUT];
      end
      for (int i = 0; i < N_WORDS_Y; i++) begin
         out_words[i] = out_reg[i*BITS_PER_WORD +: BITS_PER_WORD];
      end
   end

   assign last_out = (ocnt == OCNT_W'(N_WORDS_Y-1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      y_ready  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      case (state_q)
         S_IDLE: begin
            y_ready = 1'b1;
            if (y_valid) state_d = S_SEND;
         end
         S_SEND: begin
            tx_valid = 1'b1;
            tx_data  = out_words[ocnt];
            if (tx_ready && last_out) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg <= '0;
         ocnt    <= '0;
      end else if (state_q == S_IDLE && y_valid) begin
         out_reg <= y_trunc;
         ocnt    <= '0;
      end else if (state_q == S_SEND && tx_ready) begin
         ocnt <= last_out ? '0 : ocnt + 1'b1;
      end
   end

   assign busy = (wcnt != '0) || kx_valid || (state_q != S_IDLE);

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Bench for mvm_uart_ctrl: directed scenarios plus random frames looped through an MVM model
// with UART-rate byte pacing on both sides.
module tb_mvm_uart_ctrl;
   localparam int BIT_CLKS = 33;
   localparam int BYTE_CLKS = 10 * BIT_CLKS;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        kx_valid;
   logic        kx_ready = 1'b0;
   logic [23:0] kx_data;
   logic        y_valid = 1'b0;
   logic        y_ready;
   logic [17:0] y_data = '0;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [7:0]  tx_data;
   logic        rx_overrun;
   logic        rx_timeout;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [7:0]  exp_q[$];
   logic [23:0] frame_q[$];

   always #5 clk = ~clk;

   mvm_uart_ctrl dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .kx_valid(kx_valid), .kx_ready(kx_ready), .kx_data(kx_data),
      .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .rx_overrun(rx_overrun), .rx_timeout(rx_timeout), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   // Row r of K times x; x[c] is nibble c, k[r][c] is nibble 2+r*C+c of the frame.
   function automatic int mvm_row(input logic [23:0] f, input int r);
      int acc;
      int kv;
      int xv;
      acc = 0;
      for (int c = 0; c < 2; c++) begin
         kv = int'($signed(f[8 + (r*2 + c)*4 +: 4]));
         xv = int'($signed(f[c*4 +: 4]));
         acc += kv * xv;
      end
      return acc;
   endfunction

   task automatic test_reset();
      do_reset();
      checks++;
      if ({kx_valid, tx_valid, y_ready, rx_overrun, rx_timeout, busy} !== 6'b001000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 001000",
                  {kx_valid, tx_valid, y_ready, rx_overrun, rx_timeout, busy});
      end
      checks++;
      if (kx_data !== 24'h0) begin errors++; $display("FAIL reset_kx_data got %h exp 000000", kx_data); end
      checks++;
      if (tx_data !== 8'h0) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
   endtask

   task automatic test_assemble();
      logic [7:0] bytes [3];
      bytes = '{8'h21, 8'h43, 8'h65};
      do_reset();
      kx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_byte(bytes[i]);
         if (i < 2) begin
            checks++;
            if (kx_valid !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL asm_partial byte %0d got kx_valid=%b busy=%b exp 0 1", i, kx_valid, busy);
            end
            repeat ($urandom_range(1, 20)) tick();
         end
      end
      checks++;
      if (kx_valid !== 1'b1 || kx_data !== 24'h654321) begin
         errors++;
         $display("FAIL asm_frame got valid=%b data=%h exp 1 654321", kx_valid, kx_data);
      end
      tick();
      checks++;
      if (kx_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL asm_pulse got kx_valid=%b busy=%b exp 0 0", kx_valid, busy);
      end
      kx_ready = 1'b0;
   endtask

   task automatic test_tx_stall();
      do_reset();
      tx_ready = 1'b0;
      y_data   = {9'h011, 9'h1F5};
      y_valid  = 1'b1;
      tick();
      y_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== 8'hF5 || y_ready !== 1'b0) begin
            errors++;
            $display("FAIL tx_stall cyc %0d got valid=%b data=%h y_ready=%b exp 1 f5 0",
                     i, tx_valid, tx_data, y_ready);
         end
         tick();
      end
      tx_ready = 1'b1;
      checks++;
      if (tx_data !== 8'hF5) begin errors++; $display("FAIL tx_byte0 got %h exp f5", tx_data); end
      tick();
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
         errors++;
         $display("FAIL tx_byte1 got valid=%b data=%h exp 1 11", tx_valid, tx_data);
      end
      tick();
      tx_ready = 1'b0;
      checks++;
      if (tx_valid !== 1'b0 || y_ready !== 1'b1) begin
         errors++;
         $display("FAIL tx_done got tx_valid=%b y_ready=%b exp 0 1", tx_valid, y_ready);
      end
   endtask

   task automatic test_overrun();
      logic [23:0] fa;
      logic [23:0] fb;
      fa = 24'($urandom);
      fb = 24'($urandom);
      do_reset();
      kx_ready = 1'b0;
      for (int i = 0; i < 3; i++) send_byte(fa[i*8 +: 8]);
      checks++;
      if (kx_valid !== 1'b1 || kx_data !== fa) begin
         errors++;
         $display("FAIL ovr_first got valid=%b data=%h exp 1 %h", kx_valid, kx_data, fa);
      end
      for (int i = 0; i < 3; i++) send_byte(fb[i*8 +: 8]);
      checks++;
      if (kx_valid !== 1'b1 || kx_data !== fa || rx_overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_drop got valid=%b data=%h overrun=%b exp 1 %h 1",
                  kx_valid, kx_data, rx_overrun, fa);
      end
      kx_ready = 1'b1;
      tick();
      kx_ready = 1'b0;
      checks++;
      if (kx_valid !== 1'b0 || rx_overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_drain got valid=%b overrun=%b exp 0 1", kx_valid, rx_overrun);
      end

      do_reset();
      for (int i = 0; i < 3; i++) send_byte(fa[i*8 +: 8]);
      send_byte(fb[7:0]);
      send_byte(fb[15:8]);
      kx_ready = 1'b1;
      send_byte(fb[23:16]);
      checks++;
      if (kx_valid !== 1'b1 || kx_data !== fb || rx_overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_same_cycle got valid=%b data=%h overrun=%b exp 1 %h 0",
                  kx_valid, kx_data, rx_overrun, fb);
      end
      tick();
      kx_ready = 1'b0;
      checks++;
      if (kx_valid !== 1'b0) begin errors++; $display("FAIL ovr_same_drain got %b exp 0", kx_valid); end
   endtask

   task automatic test_timeout();
      do_reset();
      kx_ready = 1'b1;
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      repeat (1000) tick();
      checks++;
      if (rx_timeout !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL tmo_early got timeout=%b busy=%b exp 0 1", rx_timeout, busy);
      end
      repeat (30) tick();
      checks++;
      if (rx_timeout !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL tmo_fire got timeout=%b busy=%b exp 1 0", rx_timeout, busy);
      end
      send_byte(8'hAA);
      send_byte(8'hBB);
      send_byte(8'hCC);
      checks++;
      if (kx_valid !== 1'b1 || kx_data !== 24'hCCBBAA || rx_timeout !== 1'b1) begin
         errors++;
         $display("FAIL tmo_next got valid=%b data=%h timeout=%b exp 1 ccbbaa 1",
                  kx_valid, kx_data, rx_timeout);
      end
      tick();
      kx_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [23:0] fr;
      int stray;
      fr = 24'($urandom);
      do_reset();
      kx_ready = 1'b1;
      send_byte(8'($urandom));
      send_byte(8'($urandom));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({kx_valid, tx_valid, y_ready, rx_overrun, rx_timeout, busy} !== 6'b001000 ||
          kx_data !== 24'h0) begin
         errors++;
         $display("FAIL rst_mid_frame got flags=%b data=%h exp 001000 000000",
                  {kx_valid, tx_valid, y_ready, rx_overrun, rx_timeout, busy}, kx_data);
      end
      for (int i = 0; i < 3; i++) send_byte(fr[i*8 +: 8]);
      checks++;
      if (kx_valid !== 1'b1 || kx_data !== fr) begin
         errors++;
         $display("FAIL rst_next_frame got valid=%b data=%h exp 1 %h", kx_valid, kx_data, fr);
      end
      tx_ready = 1'b0;
      y_data   = 18'($urandom);
      y_valid  = 1'b1;
      tick();
      y_valid = 1'b0;
      checks++;
      if (tx_valid !== 1'b1) begin errors++; $display("FAIL rst_send_start got %b exp 1", tx_valid); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (tx_valid !== 1'b0 || y_ready !== 1'b1 || tx_data !== 8'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_send got tx_valid=%b y_ready=%b tx_data=%h busy=%b exp 0 1 00 0",
                  tx_valid, y_ready, tx_data, busy);
      end
      tx_ready = 1'b1;
      stray = 0;
      for (int i = 0; i < 10; i++) begin
         if (tx_valid) stray++;
         tick();
      end
      tx_ready = 1'b0;
      kx_ready = 1'b0;
      checks++;
      if (stray !== 0) begin errors++; $display("FAIL rst_stray_tx got %0d exp 0", stray); end
   endtask

   task automatic test_random_mvm();
      do_reset();
      kx_ready = 1'b1;
      tx_ready = 1'b1;
      exp_q.delete();
      frame_q.delete();
      fork
         begin : rx_drv
            for (int f = 0; f < 10; f++) begin
               logic [23:0] fr;
               int e0;
               int e1;
               fr = 24'($urandom);
               e0 = mvm_row(fr, 0);
               e1 = mvm_row(fr, 1);
               frame_q.push_back(fr);
               exp_q.push_back(e0[7:0]);
               exp_q.push_back(e1[7:0]);
               for (int i = 0; i < 3; i++) begin
                  send_byte(fr[i*8 +: 8]);
                  repeat (BYTE_CLKS) tick();
               end
            end
         end
         begin : mvm_core
            for (int f = 0; f < 10; f++) begin
               int budget;
               int r0;
               int r1;
               logic [23:0] ef;
               budget = 0;
               while (!kx_valid && budget < 20000) begin
                  tick();
                  budget++;
               end
               ef = (frame_q.size() > 0) ? frame_q.pop_front() : 24'hx;
               checks++;
               if (kx_valid !== 1'b1 || kx_data !== ef) begin
                  errors++;
                  $display("FAIL rnd_kx frame %0d got valid=%b data=%h exp 1 %h", f, kx_valid, kx_data, ef);
               end
               r0 = mvm_row(kx_data, 0);
               r1 = mvm_row(kx_data, 1);
               tick();
               y_data  = {r1[8:0], r0[8:0]};
               y_valid = 1'b1;
               budget  = 0;
               while (!y_ready && budget < 5000) begin
                  tick();
                  budget++;
               end
               tick();
               y_valid = 1'b0;
            end
         end
         begin : tx_sink
            int got_n;
            int budget;
            logic [7:0] got;
            logic [7:0] exp_b;
            got_n  = 0;
            budget = 0;
            while (got_n < 20 && budget < 60000) begin
               if (tx_valid) begin
                  got = tx_data;
                  tick();
                  exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hx;
                  checks++;
                  if (got !== exp_b) begin
                     errors++;
                     $display("FAIL rnd_tx byte %0d got %h exp %h", got_n, got, exp_b);
                  end
                  got_n++;
                  tx_ready = 1'b0;
                  repeat (BYTE_CLKS - 1) tick();
                  tx_ready = 1'b1;
                  budget += BYTE_CLKS;
               end else begin
                  tick();
                  budget++;
               end
            end
            checks++;
            if (got_n !== 20) begin
               errors++;
               $display("FAIL rnd_tx_count got %0d exp 20", got_n);
            end
         end
      join
      tx_ready = 1'b0;
      kx_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_assemble();
      test_tx_stall();
      test_overrun();
      test_timeout();
      test_reset_mid();
      test_random_mvm();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
